// File: rtl/note_sequencer.sv
// Note store with a registered read port and a timed playback engine for the piezo path.
// Playback walks slots 0..last, holding each note TICKS_PER_NOTE cycles with optional silence between notes.
module note_sequencer #(
  parameter int NOTE_W         = 4,
  parameter int DEPTH          = 8,
  parameter int IDX_W          = 3,
  parameter int TICKS_PER_NOTE = 5000000,
  parameter int GAP_TICKS      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [NOTE_W-1:0] wr_data,
  input  logic              clear,
  input  logic [IDX_W-1:0]  cur_index,
  output logic [NOTE_W-1:0] data_out,
  input  logic [IDX_W-1:0]  max_index,
  input  logic              play,
  input  logic              stop,
  input  logic              loop_mode,
  output logic [NOTE_W-1:0] piezo_out,
  output logic [IDX_W-1:0]  play_index,
  output logic              busy,
  output logic              done
);

  localparam int CNT_MAX = (TICKS_PER_NOTE > GAP_TICKS) ? TICKS_PER_NOTE : GAP_TICKS;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICKS_PER_NOTE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  logic [NOTE_W-1:0] mem_q [DEPTH];
  logic [NOTE_W-1:0] mem_d [DEPTH];
  logic [NOTE_W-1:0] data_q, data_d;
  logic [NOTE_W-1:0] piezo_q, piezo_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  state_t            state_q, state_d;

  logic [IDX_W-1:0]  idx_inc;
  logic [NOTE_W-1:0] note_inc;
  logic              advance;

  // Write indices with no matching slot (>= DEPTH) simply fall through unmatched.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (clear) begin
        mem_d[i] = '0;
      end else if (wr_en && (wr_index == IDX_W'(i))) begin
        mem_d[i] = wr_data;
      end
    end
  end

  always_comb begin
    data_d   = '0;
    note_inc = '0;
    idx_inc  = idx_q + 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (cur_index == IDX_W'(i)) data_d = mem_q[i];
      if (idx_inc == IDX_W'(i))   note_inc = mem_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    piezo_d = piezo_q;
    done_d  = 1'b0;
    advance = 1'b0;

    if (state_q == S_IDLE) begin
      if (play && !stop) begin
        last_d  = (max_index > LAST_SLOT) ? LAST_SLOT : max_index;
        idx_d   = '0;
        piezo_d = mem_q[0];
        cnt_d   = '0;
        state_d = S_PLAY;
      end
    end else if (stop) begin
      state_d = S_IDLE;
      piezo_d = '0;
      idx_d   = '0;
      cnt_d   = '0;
    end else if (state_q == S_PLAY) begin
      if (cnt_q == TICK_LAST) begin
        cnt_d = '0;
        if (GAP_TICKS > 0) begin
          piezo_d = '0;
          state_d = S_GAP;
        end else begin
          advance = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      if (cnt_q == GAP_LAST) begin
        cnt_d   = '0;
        advance = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Notes are fetched from live memory at load time, so later slots pick up fresh writes.
    if (advance) begin
      if (idx_q < last_q) begin
        idx_d   = idx_inc;
        piezo_d = note_inc;
        state_d = S_PLAY;
      end else if (loop_mode) begin
        idx_d   = '0;
        piezo_d = mem_q[0];
        state_d = S_PLAY;
      end else begin
        idx_d   = '0;
        piezo_d = '0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      data_q  <= '0;
      piezo_q <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      state_q <= S_IDLE;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      data_q  <= data_d;
      piezo_q <= piezo_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      state_q <= state_d;
    end
  end

  assign data_out   = data_q;
  assign piezo_out  = piezo_q;
  assign play_index = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: two instances (no gap / 2-cycle gap) share stimulus and are
// checked every cycle against a time-based playback model, plus hand-computed expectations.
module tb_note_sequencer;

  localparam int TPN = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_index = '0;
  logic [3:0] wr_data = '0;
  logic       clear = 1'b0;
  logic [3:0] cur_index = '0;
  logic [3:0] max_index = '0;
  logic       play = 1'b0;
  logic       stop = 1'b0;
  logic       loop_mode = 1'b0;

  logic [3:0] data_o  [2];
  logic [3:0] piezo_o [2];
  logic [3:0] pidx_o  [2];
  logic       busy_o  [2];
  logic       done_o  [2];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      note_sequencer #(
        .NOTE_W(4), .DEPTH(8), .IDX_W(4), .TICKS_PER_NOTE(TPN), .GAP_TICKS(2 * gi)
      ) u_dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
        .clear(clear), .cur_index(cur_index), .data_out(data_o[gi]), .max_index(max_index),
        .play(play), .stop(stop), .loop_mode(loop_mode), .piezo_out(piezo_o[gi]),
        .play_index(pidx_o[gi]), .busy(busy_o[gi]), .done(done_o[gi])
      );
    end
  endgenerate

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a run is tracked as elapsed cycles since its start; slot boundaries fall on
  // multiples of (note + gap) length, and the note heard is the memory value at that boundary.
  int m_mem [8];
  int m_data [2];
  int m_piezo [2];
  int m_idx [2];
  int m_last [2];
  int m_e [2];
  int m_done [2];
  int m_active [2];
  int gap_of [2] = '{0, 2};

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      for (int i = 0; i < 8; i++) m_mem[i] = 0;
      for (int k = 0; k < 2; k++) begin
        m_data[k] = 0; m_piezo[k] = 0; m_idx[k] = 0; m_last[k] = 0;
        m_e[k] = 0; m_done[k] = 0; m_active[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_data[k] = (cur_index < 8) ? m_mem[cur_index] : 0;
        m_done[k] = 0;
        if (m_active[k] == 0) begin
          if (play && !stop) begin
            m_active[k] = 1;
            m_last[k]   = (max_index > 7) ? 7 : int'(max_index);
            m_e[k]      = 0;
            m_idx[k]    = 0;
            m_piezo[k]  = m_mem[0];
          end
        end else if (stop) begin
          m_active[k] = 0; m_idx[k] = 0; m_piezo[k] = 0;
        end else begin
          m_e[k]++;
          if (gap_of[k] > 0 && (m_e[k] % (TPN + gap_of[k])) == TPN) m_piezo[k] = 0;
          if ((m_e[k] % (TPN + gap_of[k])) == 0) begin
            if (m_idx[k] < m_last[k]) begin
              m_idx[k]++;
              m_piezo[k] = m_mem[m_idx[k]];
            end else if (loop_mode) begin
              m_idx[k] = 0; m_e[k] = 0; m_piezo[k] = m_mem[0];
            end else begin
              m_active[k] = 0; m_idx[k] = 0; m_piezo[k] = 0; m_done[k] = 1;
            end
          end
        end
      end
      if (clear) for (int i = 0; i < 8; i++) m_mem[i] = 0;
      else if (wr_en && wr_index < 8) m_mem[wr_index] = wr_data;
    end
  end

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("data_out[%0d]", k),   data_o[k],  m_data[k]);
      chk($sformatf("piezo_out[%0d]", k),  piezo_o[k], m_piezo[k]);
      chk($sformatf("play_index[%0d]", k), pidx_o[k],  m_idx[k]);
      chk($sformatf("busy[%0d]", k),       busy_o[k],  m_active[k]);
      chk($sformatf("done[%0d]", k),       done_o[k],  m_done[k]);
    end
  end

  int p0 [128];
  int p1 [128];
  int b0, b1, d0, d1, z1;

  task automatic write_slot(input int idx, input int val);
    wr_en = 1'b1; wr_index = 4'(idx); wr_data = 4'(val);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // scen 1: stop at cycle 9; scen 2: rewrite sounding slot, re-play while busy, write slot 2.
  task automatic run_play(input int scen, input int mi, input logic lm);
    max_index = 4'(mi); loop_mode = lm; play = 1'b1;
    @(negedge clk);
    play = 1'b0;
    b0 = 0; b1 = 0; d0 = 0; d1 = 0; z1 = 0;
    for (int c = 0; c < 128; c++) begin
      p0[c] = 0; p1[c] = 0;
    end
    for (int c = 0; c < 128; c++) begin
      p0[c] = piezo_o[0]; p1[c] = piezo_o[1];
      if (busy_o[0]) b0++;
      if (busy_o[1]) begin
        b1++;
        if (piezo_o[1] == 0) z1++;
      end
      d0 += int'(done_o[0]); d1 += int'(done_o[1]);
      wr_en = 1'b0; stop = 1'b0; play = 1'b0;
      if (scen == 1 && c == 9) stop = 1'b1;
      if (scen == 2 && c == 1) begin
        wr_en = 1'b1; wr_index = 4'd0; wr_data = 4'hC;
      end
      if (scen == 2 && c == 5) begin
        play = 1'b1; max_index = 4'd0;
        wr_en = 1'b1; wr_index = 4'd2; wr_data = 4'hF;
      end
      if (c > 0 && !busy_o[0] && !busy_o[1]) break;
      @(negedge clk);
    end
    chk("run_bounded", int'(busy_o[0] | busy_o[1]), 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_piezo", piezo_o[0], 0);
    chk("reset_busy", busy_o[0], 0);
    chk("reset_data", data_o[1], 0);
    reset = 1'b1;

    for (int i = 0; i < 8; i++) write_slot(i, i + 1);
    write_slot(9, 15);
    for (int i = 0; i <= 8; i++) begin
      cur_index = 4'(i);
      @(negedge clk);
      chk($sformatf("read_slot%0d", i), data_o[0], (i < 8) ? i + 1 : 0);
    end
    cur_index = 4'd2; wr_en = 1'b1; wr_index = 4'd2; wr_data = 4'hA;
    @(negedge clk);
    wr_en = 1'b0;
    chk("rbw_old", data_o[0], 3);
    @(negedge clk);
    chk("rbw_new", data_o[0], 10);
    clear = 1'b1; wr_en = 1'b1; wr_index = 4'd5; wr_data = 4'h7;
    @(negedge clk);
    clear = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cur_index = 4'(i);
      @(negedge clk);
      chk($sformatf("cleared_slot%0d", i), data_o[1], 0);
    end

    write_slot(0, 3); write_slot(1, 5); write_slot(2, 7); write_slot(3, 9);
    write_slot(4, 1); write_slot(5, 2); write_slot(6, 4); write_slot(7, 6);

    run_play(0, 3, 1'b0);
    chk("basic_busy0", b0, 16);
    chk("basic_busy1", b1, 24);
    chk("basic_done0", d0, 1);
    chk("basic_done1", d1, 1);
    chk("basic_n0", p0[0], 3);
    chk("basic_n1", p0[4], 5);
    chk("basic_n2", p0[8], 7);
    chk("basic_n3", p0[12], 9);
    chk("basic_after", p0[16], 0);
    chk("gap_first", p1[4], 0);
    chk("gap_next", p1[6], 5);
    chk("gap_last", p1[18], 9);

    run_play(0, 15, 1'b0);
    chk("clamp_busy0", b0, 32);
    chk("clamp_busy1", b1, 48);
    chk("clamp_gapzero1", z1, 16);
    chk("clamp_slot7", p0[28], 6);

    run_play(1, 1, 1'b1);
    loop_mode = 1'b0;
    chk("loop_a", p0[0], 3);
    chk("loop_b", p0[4], 5);
    chk("loop_wrap", p0[8], 3);
    chk("stop_busy0", b0, 10);
    chk("stop_busy1", b1, 10);
    chk("stop_nodone", d0 + d1, 0);
    chk("stop_silent", p0[10], 0);

    play = 1'b1; stop = 1'b1;
    @(negedge clk);
    play = 1'b0; stop = 1'b0;
    chk("playstop_busy0", busy_o[0], 0);
    chk("playstop_busy1", busy_o[1], 0);

    run_play(2, 3, 1'b0);
    chk("rewrite_sounding", p0[2], 3);
    chk("live_write", p0[8], 15);
    chk("replay_busy0", b0, 16);
    chk("replay_done0", d0, 1);

    cur_index = 4'd0; max_index = 4'd3; play = 1'b1;
    @(negedge clk);
    play = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("areset_piezo0", piezo_o[0], 0);
    chk("areset_busy0", busy_o[0], 0);
    chk("areset_idx0", pidx_o[0], 0);
    chk("areset_data0", data_o[0], 0);
    chk("areset_piezo1", piezo_o[1], 0);
    @(negedge clk);
    reset = 1'b1; cur_index = 4'd2;
    @(negedge clk);
    chk("areset_mem2", data_o[0], 0);
    cur_index = 4'd0;
    @(negedge clk);
    chk("areset_mem0", data_o[1], 0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
